// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage access unit and the load sign extender.
package mem_access_pkg;

  // Access-size encodings; 101-111 are illegal and fault on acceptance.
  typedef enum logic [2:0] {
    CtrlWord  = 3'b000,
    CtrlHalf  = 3'b001,
    CtrlByte  = 3'b010,
    CtrlHalfU = 3'b011,
    CtrlByteU = 3'b100
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Pipeline request/response and data-memory port bundle for data_mem_access_unit.
interface data_mem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_data;
  logic [2:0]  resp_ctrl;
  logic        resp_misaligned;
  logic        resp_bus_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // The access unit's view.
  modport slave (
    input  req_valid, req_we, req_ctrl, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready,
    output resp_valid, resp_data, resp_ctrl, resp_misaligned, resp_bus_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // The pipeline-plus-memory environment's view.
  modport master (
    output req_valid, req_we, req_ctrl, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready,
    input  resp_valid, resp_data, resp_ctrl, resp_misaligned, resp_bus_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: legality check, byte enables, store replication and load alignment.
module mem_lane_steer
  import mem_access_pkg::*;
(
  input  logic [2:0]  ctrl_i,
  input  logic        we_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        fault_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    fault_o = 1'b0;
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = shifted;
    case (ctrl_i)
      CtrlWord: begin
        fault_o = (off_i != 2'b00);
      end
      CtrlHalf, CtrlHalfU: begin
        // Unsigned variants only make sense for loads.
        fault_o = off_i[0] | (we_i & (ctrl_i == CtrlHalfU));
        be_o    = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0000, shifted[15:0]};
      end
      CtrlByte, CtrlByteU: begin
        fault_o = we_i & (ctrl_i == CtrlByteU);
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h000000, shifted[7:0]};
      end
      default: begin
        fault_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// Memory-stage load/store unit: alignment check, word-addressed memory port, timeout.
module data_mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned Timeout = 255
) (
  input logic                   clk_i,
  input logic                   reset_i,
  data_mem_access_unit_if.slave bus
);

  lsu_state_t  state_q;
  logic [31:0] cnt_q;
  logic [2:0]  ctrl_q;
  logic [1:0]  off_q;
  logic        we_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;

  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic [2:0]  resp_ctrl_q;
  logic        resp_mis_q;
  logic        resp_err_q;

  logic        idle;
  logic        timeout_hit;
  logic        done;
  logic        bus_err;

  logic [2:0]  steer_ctrl;
  logic        steer_we;
  logic [1:0]  steer_off;
  logic        steer_fault;
  logic [3:0]  steer_be;
  logic [31:0] steer_wdata;
  logic [31:0] steer_rdata;

  assign idle        = (state_q == StIdle);
  assign timeout_hit = (Timeout != 0) && ((cnt_q + 32'd1) == Timeout);

  // Steer from the live request while idle, from the latched access otherwise.
  assign steer_ctrl = idle ? bus.req_ctrl       : ctrl_q;
  assign steer_we   = idle ? bus.req_we         : we_q;
  assign steer_off  = idle ? bus.req_addr[1:0]  : off_q;

  mem_lane_steer u_steer (
    .ctrl_i  (steer_ctrl),
    .we_i    (steer_we),
    .off_i   (steer_off),
    .wdata_i (bus.req_wdata),
    .rdata_i (bus.mem_rdata),
    .fault_o (steer_fault),
    .be_o    (steer_be),
    .wdata_o (steer_wdata),
    .rdata_o (steer_rdata)
  );

  // Completion of an in-flight access, either normally or by timeout.
  always_comb begin
    done    = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      StReq: begin
        done    = (bus.mem_gnt && (we_q || bus.mem_rvalid)) || (!bus.mem_gnt && timeout_hit);
        bus_err = !bus.mem_gnt && timeout_hit;
      end
      StWait: begin
        done    = bus.mem_rvalid || timeout_hit;
        bus_err = !bus.mem_rvalid && timeout_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ctrl_q       <= '0;
      off_q        <= '0;
      we_q         <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_ctrl_q  <= '0;
      resp_mis_q   <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      cnt_q        <= cnt_q + 32'd1;
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            if (steer_fault) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= '0;
              resp_ctrl_q  <= bus.req_ctrl;
              resp_mis_q   <= 1'b1;
              resp_err_q   <= 1'b0;
            end else begin
              ctrl_q      <= bus.req_ctrl;
              off_q       <= bus.req_addr[1:0];
              we_q        <= bus.req_we;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
              mem_be_q    <= steer_be;
              mem_wdata_q <= steer_wdata;
              cnt_q       <= '0;
              state_q     <= StReq;
            end
          end
        end
        StReq, StWait: begin
          if (done) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= (bus_err || we_q) ? 32'h0 : steer_rdata;
            resp_ctrl_q  <= ctrl_q;
            resp_mis_q   <= 1'b0;
            resp_err_q   <= bus_err;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            state_q      <= StIdle;
          end else if ((state_q == StReq) && bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready       = idle;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_data       = resp_data_q;
  assign bus.resp_ctrl       = resp_ctrl_q;
  assign bus.resp_misaligned = resp_mis_q;
  assign bus.resp_bus_err    = resp_err_q;
  assign bus.mem_req         = mem_req_q;
  assign bus.mem_we          = mem_we_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_be          = mem_be_q;
  assign bus.mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: directed scenarios plus randomized accesses.
module tb_data_mem_access_unit;
  import mem_access_pkg::*;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  data_mem_access_unit_if bus();

  data_mem_access_unit #(.Timeout(T)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic        ready1;
    logic        any_req;
    logic        stable;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        mwe;
    logic [31:0] rdata;
    logic [2:0]  rctrl;
    logic        mis;
    logic        err;
    logic        ready_at_resp;
  } obs_t;

  typedef struct {
    int          lat;
    logic        fault;
    logic        err;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rdata;
  } exp_t;

  // Expected outcome from the access rules: size, alignment, lane placement and wait budget.
  function automatic exp_t model(input logic we, input logic [2:0] ctrl,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int gd, input int rd);
    exp_t e;
    int   size;
    int   off;
    off     = int'(addr % 4);
    size    = (ctrl == 3'd0) ? 4 : ((ctrl == 3'd1) || (ctrl == 3'd3)) ? 2 : 1;
    e.fault = (ctrl > 3'd4) || (we && (ctrl > 3'd2)) || ((off % size) != 0);
    e.maddr = addr - 32'(off);
    e.be    = 4'(((1 << size) - 1) << off);
    if (size == 4)      e.mwdata = wdata;
    else if (size == 2) e.mwdata = 32'(wdata[15:0]) * 32'h0001_0001;
    else                e.mwdata = 32'(wdata[7:0]) * 32'h0101_0101;
    e.err   = 1'b0;
    e.rdata = 32'h0;
    if (e.fault) begin
      e.lat = 1;
    end else if (gd < 0 || gd >= T) begin
      e.err = 1'b1;
      e.lat = 1 + T;
    end else if (we) begin
      e.lat = 2 + gd;
    end else if (rd < 0 || rd > T) begin
      e.err = 1'b1;
      e.lat = 2 + gd + T;
    end else begin
      e.lat   = 2 + gd + rd;
      e.rdata = (rdata >> (8 * off)) &
                ((size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1));
    end
    return e;
  endfunction

  // Issue one access; memory grants gd cycles after mem_req rises, rvalid rd cycles after gnt.
  task automatic run_access(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int gd, input int rd, output obs_t o);
    o.lat = -1; o.ready1 = 1'bx; o.any_req = 1'b0; o.stable = 1'b1;
    o.maddr = '0; o.be = '0; o.mwdata = '0; o.mwe = 1'b0;
    o.rdata = 'x; o.rctrl = 'x; o.mis = 1'bx; o.err = 1'bx; o.ready_at_resp = 1'bx;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_ctrl  = ctrl;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) o.ready1 = bus.req_ready;
      if (bus.mem_req) begin
        if (!o.any_req) begin
          o.maddr = bus.mem_addr; o.be = bus.mem_be; o.mwdata = bus.mem_wdata; o.mwe = bus.mem_we;
        end else if ({bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.mem_we} !==
                     {o.maddr, o.be, o.mwdata, o.mwe}) begin
          o.stable = 1'b0;
        end
        o.any_req = 1'b1;
      end
      if (bus.resp_valid) begin
        o.lat = c; o.rdata = bus.resp_data; o.rctrl = bus.resp_ctrl;
        o.mis = bus.resp_misaligned; o.err = bus.resp_bus_err; o.ready_at_resp = bus.req_ready;
        break;
      end
      bus.mem_gnt    = bus.mem_req && (gd >= 0) && (c == 1 + gd);
      bus.mem_rvalid = !we && (gd >= 0) && (rd >= 0) && (c == 1 + gd + rd);
      bus.mem_rdata  = bus.mem_rvalid ? rdata : $urandom;
      @(posedge clk); #1;
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_ctrl = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 70'h0) begin
      errors++; $display("FAIL reset_mem: got %h want 0",
                         {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata});
    end
    checks++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_ctrl, bus.resp_misaligned, bus.resp_bus_err}
        !== 38'h0) begin
      errors++; $display("FAIL reset_resp: got %h want 0", {bus.resp_valid, bus.resp_data,
                         bus.resp_ctrl, bus.resp_misaligned, bus.resp_bus_err});
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.mem_req} !== 3'b100) begin
      errors++; $display("FAIL post_reset_idle: got %b want 100",
                         {bus.req_ready, bus.resp_valid, bus.mem_req});
    end
  endtask

  task automatic test_store_byte();
    obs_t o;
    run_access(1'b1, 3'b010, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, -1, o);
    checks++;
    if ({o.maddr, o.be, o.mwe} !== {32'h0000_1000, 4'b1000, 1'b1}) begin
      errors++; $display("FAIL store_byte_port: got addr %h be %b we %b want 00001000 1000 1",
                         o.maddr, o.be, o.mwe);
    end
    checks++;
    if (o.mwdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL store_byte_wdata: got %h want a5a5a5a5", o.mwdata);
    end
    checks++;
    if (o.lat !== 2 || o.mis !== 1'b0 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
      errors++; $display("FAIL store_byte_resp: got lat %0d mis %b err %b data %h want 2 0 0 0",
                         o.lat, o.mis, o.err, o.rdata);
    end
  endtask

  task automatic test_load_half();
    obs_t o;
    run_access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1, 1, o);
    checks++;
    if (o.rdata !== 32'h0000_BEEF || o.rctrl !== 3'b001) begin
      errors++; $display("FAIL load_half_data: got %h ctrl %b want 0000beef 001", o.rdata, o.rctrl);
    end
    checks++;
    if (o.lat !== 4 || o.be !== 4'b1100 || o.maddr !== 32'h0000_2000 || o.stable !== 1'b1) begin
      errors++; $display("FAIL load_half_port: got lat %0d be %b addr %h stable %b want 4 1100 2000 1",
                         o.lat, o.be, o.maddr, o.stable);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0000_BEEF) begin
      errors++; $display("FAIL resp_hold: got valid %b data %h want 0 0000beef",
                         bus.resp_valid, bus.resp_data);
    end
  endtask

  task automatic test_faults();
    logic [2:0]  fc [4] = '{3'b000, 3'b111, 3'b011, 3'b001};
    logic        fw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] fa [4] = '{32'h3001, 32'h3000, 32'h3000, 32'h3003};
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      run_access(fw[i], fc[i], fa[i], 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, o);
      checks++;
      if (o.lat !== 1 || o.mis !== 1'b1 || o.err !== 1'b0 || o.rdata !== 32'h0 ||
          o.rctrl !== fc[i] || o.any_req !== 1'b0 || o.ready1 !== 1'b1) begin
        errors++; $display("FAIL fault_%0d: got lat %0d mis %b err %b data %h ctrl %b req %b rdy %b want 1 1 0 0 %b 0 1",
                           i, o.lat, o.mis, o.err, o.rdata, o.rctrl, o.any_req, o.ready1, fc[i]);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b0, 3'b000, 32'h0000_6000, 32'h0, 32'h0, 0, -1, o);
    checks++;
    if (o.lat !== 2 + T || o.err !== 1'b1 || o.mis !== 1'b0 || o.rdata !== 32'h0 ||
        o.ready_at_resp !== 1'b1) begin
      errors++; $display("FAIL wait_timeout: got lat %0d err %b mis %b data %h rdy %b want %0d 1 0 0 1",
                         o.lat, o.err, o.mis, o.rdata, o.ready_at_resp, 2 + T);
    end
    run_access(1'b1, 3'b000, 32'h0000_6004, 32'h55, 32'h0, -1, -1, o);
    checks++;
    if (o.lat !== 1 + T || o.err !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL req_timeout: got lat %0d err %b mem_req %b want %0d 1 0",
                         o.lat, o.err, bus.mem_req, 1 + T);
    end
  endtask

  task automatic test_reset_mid_access();
    logic saw_resp;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_ctrl = 3'b000; bus.req_addr = 32'h500;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.mem_req, bus.req_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_in_req: got mem_req %b ready %b want 0 1",
                         bus.mem_req, bus.req_ready);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.mem_req} !== 3'b100) begin
      errors++; $display("FAIL reset_in_wait: got rdy/valid/req %b want 100",
                         {bus.req_ready, bus.resp_valid, bus.mem_req});
    end
    #2 reset = 1'b0;
    saw_resp = 1'b0;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) saw_resp = 1'b1;
    end
    bus.mem_rvalid = 1'b0;
    checks++;
    if (saw_resp !== 1'b0) begin
      errors++; $display("FAIL late_rvalid: got resp_valid %b want 0", saw_resp);
    end
  endtask

  task automatic test_load_byteu_same_cycle();
    obs_t o;
    run_access(1'b0, 3'b100, 32'h0000_4002, 32'h0, 32'h00C3_0000, 0, 0, o);
    checks++;
    if (o.rdata !== 32'h0000_00C3 || o.rctrl !== 3'b100 || o.lat !== 2 || o.be !== 4'b0100) begin
      errors++; $display("FAIL load_byteu: got data %h ctrl %b lat %0d be %b want 000000c3 100 2 0100",
                         o.rdata, o.rctrl, o.lat, o.be);
    end
  endtask

  task automatic test_random(input int n);
    obs_t        o;
    exp_t        e;
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr, wdata, rdata;
    int          gd, rd;
    for (int i = 0; i < n; i++) begin
      we    = 1'($urandom_range(0, 1));
      ctrl  = 3'($urandom_range(0, 5));
      if (ctrl == 3'd5) ctrl = 3'($urandom_range(5, 7));
      addr  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (ctrl == 3'd0) addr[1:0] = 2'b00;
        else if (ctrl == 3'd1 || ctrl == 3'd3) addr[0] = 1'b0;
      end
      wdata = $urandom;
      rdata = $urandom;
      gd    = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) gd = -1;
      rd    = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) rd = -1;
      e = model(we, ctrl, addr, wdata, rdata, gd, rd);
      run_access(we, ctrl, addr, wdata, rdata, gd, rd, o);
      checks++;
      if (o.lat !== e.lat || o.mis !== e.fault || o.err !== e.err || o.rdata !== e.rdata ||
          o.rctrl !== ctrl || o.ready_at_resp !== 1'b1) begin
        errors++; $display("FAIL rand_resp[%0d] we%b ctrl%b addr %h: got lat %0d mis %b err %b data %h ctrl %b rdy %b want %0d %b %b %h %b 1",
                           i, we, ctrl, addr, o.lat, o.mis, o.err, o.rdata, o.rctrl,
                           o.ready_at_resp, e.lat, e.fault, e.err, e.rdata, ctrl);
      end
      checks++;
      if (e.fault) begin
        if (o.any_req !== 1'b0 || o.ready1 !== 1'b1) begin
          errors++; $display("FAIL rand_fault_port[%0d]: got req %b rdy %b want 0 1",
                             i, o.any_req, o.ready1);
        end
      end else if (o.any_req !== 1'b1 || o.ready1 !== 1'b0 || o.stable !== 1'b1 ||
                   o.maddr !== e.maddr || o.be !== e.be || o.mwe !== we ||
                   (we && o.mwdata !== e.mwdata)) begin
        errors++; $display("FAIL rand_port[%0d]: got req %b rdy %b stable %b addr %h be %b we %b wd %h want 1 0 1 %h %b %b %h",
                           i, o.any_req, o.ready1, o.stable, o.maddr, o.be, o.mwe, o.mwdata,
                           e.maddr, e.be, we, e.mwdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_faults();
    test_timeout();
    test_reset_mid_access();
    test_load_byteu_same_cycle();
    test_random(200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
